wq2_rptr_flowctl: RTL and testbench
===================================

// Module: wq2_rptr_flowctl
// PURPOSE
//  Write-domain companion to the async FIFO write-pointer/full logic. Synchronizes the read-side
//  Gray pointer into wclk, decodes Gray->binary for both pointers, computes FIFO fill level and
//  almost-full, and runs an XOFF/XON flow-control FSM that requests the UART TX to pause/resume
//  the remote sender. Also flags overflow attempts and corrupted (non-Gray) pointer transitions.
// PARAMETERS
//  ADDRSIZE     4   FIFO address width; pointers are ADDRSIZE+1 bits, depth = 2**ADDRSIZE
//  SYNC_STAGES  2   flops in rptr synchronizer chain (>=2)
//  HI_MARK      12  level at/above which XOFF is requested (LO_MARK < HI_MARK <= 2**ADDRSIZE)
//  LO_MARK      4   level at/below which XON is requested
// PORTS
//  wclk         in   1           write-domain clock
//  wrst_n       in   1           asynchronous, active-low reset
//  rptr         in   ADDRSIZE+1  read pointer, Gray, from read clock domain (asynchronous)
//  wptr         in   ADDRSIZE+1  write pointer, Gray, registered in wclk domain
//  winc         in   1           write request (same signal driving write-pointer logic)
//  wfull        in   1           registered full flag from write-pointer logic
//  werr_clr     in   1           clears woverflow and wgray_err
//  wflow_ack    in   1           UART TX accepted pending XOFF/XON request
//  wq2_rptr     out  ADDRSIZE+1  synchronized read pointer, Gray (feeds full compare)
//  wlevel       out  ADDRSIZE+1  FIFO fill level, 0..2**ADDRSIZE
//  walmost_full out  1           wlevel >= HI_MARK
//  wxoff_req    out  1           request UART TX to send XOFF
//  wxon_req     out  1           request UART TX to send XON
//  wpaused      out  1           remote sender is (being) held off
//  woverflow    out  1           sticky: write attempted while full
//  wgray_err    out  1           sticky: synced rptr changed by >1 bit in one wclk
// BEHAVIOUR
//  - Reset: all sync flops, wq2_rptr, wlevel, flags, requests = 0; FSM = RUN.
//  - Sync: rptr passes SYNC_STAGES flops; wq2_rptr = last stage. Latency SYNC_STAGES wclk.
//  - Gray->bin: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]; applied to wptr and wq2_rptr, combinational.
//  - wlevel registered: (wbin - rbin) mod 2**(ADDRSIZE+1); 1 wclk after wptr/wq2_rptr change.
//    Pointer wrap (MSB toggle) handled by modulo subtract; level 2**ADDRSIZE == full.
//  - walmost_full registered from same next-level value as wlevel (updates same cycle).
//  - wgray_err: set when popcount(wq2_rptr_next ^ wq2_rptr) > 1, or computed level > 2**ADDRSIZE.
//  - woverflow: set when winc && wfull. Sticky flags clear on werr_clr; set wins if same cycle.
//  - FSM (registered outputs decoded from state):
//      RUN:      level >= HI_MARK -> XOFF_REQ
//      XOFF_REQ: wxoff_req=1; wflow_ack -> PAUSED
//      PAUSED:   level <= LO_MARK -> XON_REQ
//      XON_REQ:  wxon_req=1;  wflow_ack -> RUN
//    wpaused=1 in PAUSED and XON_REQ. wflow_ack ignored in RUN/PAUSED.
//    Requests held stable until acked; level changes during a request do not abort it.
//    wxoff_req and wxon_req never both 1.
//  - Reset mid-request: request dropped immediately (async), FSM returns to RUN.
// TESTING
//  1 Reset: wrst_n=0 with rptr=5'b10110 -> all outputs 0; after release wq2_rptr=rptr 2 wclk later.
//  2 Fill: wptr steps Gray(0..12), rptr=0 -> wlevel=12, walmost_full=1, wxoff_req=1 next cycle;
//    ack -> wpaused=1, wxoff_req=0.
//  3 Drain: from PAUSED, rptr steps to Gray(8) -> wlevel=4 -> wxon_req=1; ack -> RUN, wpaused=0.
//  4 Wrap: wptr=Gray(18), rptr=Gray(3) -> wlevel=15; wptr=Gray(19), rptr=Gray(3) -> wlevel=16.
//  5 Errors: rptr jump 5'b00000->5'b00011 -> wgray_err=1; winc=1 with wfull=1 -> woverflow=1;
//    werr_clr -> both 0; werr_clr with winc&wfull same cycle -> woverflow stays 1.
//  6 Reset during XOFF_REQ -> wxoff_req=0 asynchronously, FSM RUN after release.

Source files
------------

// File: rtl/wq2_rptr_flowctl.sv
// Write-domain side of an async FIFO: synchronizes the read pointer, derives fill level and
// almost-full, and drives the XOFF/XON pause/resume handshake toward the UART transmitter.
module wq2_rptr_flowctl #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HI_MARK     = 12,
    parameter int LO_MARK     = 4
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic                winc,
    input  logic                wfull,
    input  logic                werr_clr,
    input  logic                wflow_ack,
    output logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                wxoff_req,
    output logic                wxon_req,
    output logic                wpaused,
    output logic                woverflow,
    output logic                wgray_err
);

    localparam int P = ADDRSIZE + 1;
    localparam logic [P-1:0] DEPTH   = P'(1 << ADDRSIZE);
    localparam logic [P-1:0] HI_LVL  = P'(HI_MARK);
    localparam logic [P-1:0] LO_LVL  = P'(LO_MARK);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_XOFF   = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_XON    = 2'd3;

    logic [P-1:0] sync_q [SYNC_STAGES];
    logic [P-1:0] sync_d [SYNC_STAGES];
    logic [P-1:0] wlevel_q, wlevel_d;
    logic         walmost_full_q, walmost_full_d;
    logic         woverflow_q, woverflow_d;
    logic         wgray_err_q, wgray_err_d;
    logic [1:0]   state_q, state_d;

    logic [P-1:0] wbin;
    logic [P-1:0] rbin;
    logic         gray_bad;

    function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
        logic [P-1:0] b;
        b[P-1] = g[P-1];
        for (int i = P - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        sync_d[0] = rptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign wq2_rptr = sync_q[SYNC_STAGES-1];
    assign wbin     = gray2bin(wptr);
    assign rbin     = gray2bin(wq2_rptr);

    // Modulo subtract absorbs the pointer wrap; anything above DEPTH means a corrupt pointer.
    always_comb begin
        wlevel_d       = wbin - rbin;
        walmost_full_d = (wlevel_d >= HI_LVL);
        gray_bad       = ($countones(sync_d[SYNC_STAGES-1] ^ wq2_rptr) > 1) ||
                         (wlevel_d > DEPTH);
        wgray_err_d    = (wgray_err_q & ~werr_clr) | gray_bad;
        woverflow_d    = (woverflow_q & ~werr_clr) | (winc & wfull);
    end

    // Flow control reacts to the registered level, so it trails wlevel by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (wlevel_q >= HI_LVL) state_d = ST_XOFF;
            ST_XOFF:   if (wflow_ack)          state_d = ST_PAUSED;
            ST_PAUSED: if (wlevel_q <= LO_LVL) state_d = ST_XON;
            ST_XON:    if (wflow_ack)          state_d = ST_RUN;
            default:                           state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
            wgray_err_q    <= 1'b0;
            state_q        <= ST_RUN;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            wlevel_q       <= wlevel_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
            wgray_err_q    <= wgray_err_d;
            state_q        <= state_d;
        end
    end

    assign wlevel       = wlevel_q;
    assign walmost_full = walmost_full_q;
    assign woverflow    = woverflow_q;
    assign wgray_err    = wgray_err_q;
    assign wxoff_req    = (state_q == ST_XOFF);
    assign wxon_req     = (state_q == ST_XON);
    assign wpaused      = (state_q == ST_PAUSED) || (state_q == ST_XON);

endmodule

// File: tb/tb_wq2_rptr_flowctl.sv
// Bench for wq2_rptr_flowctl: directed scenarios followed by random pointer traffic, every
// cycle compared against a queue/arithmetic reference of the write-side flow control.
module tb_wq2_rptr_flowctl;

    localparam int AW   = 4;
    localparam int P    = AW + 1;
    localparam int SYNC = 2;
    localparam int HI   = 12;
    localparam int LO   = 4;

    logic         wclk = 1'b0;
    logic         wrst_n = 1'b0;
    logic [P-1:0] rptr = '0;
    logic [P-1:0] wptr = '0;
    logic         winc = 1'b0;
    logic         wfull = 1'b0;
    logic         werr_clr = 1'b0;
    logic         wflow_ack = 1'b0;
    logic [P-1:0] wq2_rptr;
    logic [P-1:0] wlevel;
    logic         walmost_full;
    logic         wxoff_req;
    logic         wxon_req;
    logic         wpaused;
    logic         woverflow;
    logic         wgray_err;

    wq2_rptr_flowctl #(
        .ADDRSIZE(AW), .SYNC_STAGES(SYNC), .HI_MARK(HI), .LO_MARK(LO)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wptr(wptr), .winc(winc),
        .wfull(wfull), .werr_clr(werr_clr), .wflow_ack(wflow_ack),
        .wq2_rptr(wq2_rptr), .wlevel(wlevel), .walmost_full(walmost_full),
        .wxoff_req(wxoff_req), .wxon_req(wxon_req), .wpaused(wpaused),
        .woverflow(woverflow), .wgray_err(wgray_err)
    );

    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: rptr history queue, level, sticky flags, pause/request flags.
    logic [P-1:0] hist[$];
    int           m_level;
    bit           m_almost, m_ov, m_err, m_paused, m_req;

    function automatic logic [P-1:0] g2b(input logic [P-1:0] g);
        logic [P-1:0] b;
        b = g;
        for (int i = 1; i < P; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [P-1:0] b2g(input int b);
        logic [P-1:0] v;
        v = P'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back('0);
        m_level  = 0;
        m_almost = 0;
        m_ov     = 0;
        m_err    = 0;
        m_paused = 0;
        m_req    = 0;
    endtask

    task automatic model_step();
        logic [P-1:0] old_wq2, new_wq2;
        int old_level, lvl;
        bit bad;
        old_wq2   = hist[0];
        old_level = m_level;
        hist.push_back(rptr);
        void'(hist.pop_front());
        new_wq2 = hist[0];
        lvl = int'((g2b(wptr) - g2b(old_wq2)) & P'((1 << P) - 1));
        bad = ($countones(new_wq2 ^ old_wq2) > 1) || (lvl > (1 << AW));
        m_err    = (m_err && !werr_clr) || bad;
        m_ov     = (m_ov && !werr_clr) || (winc && wfull);
        m_level  = lvl;
        m_almost = (lvl >= HI);
        if (!m_req) begin
            if (!m_paused && old_level >= HI) m_req = 1;
            else if (m_paused && old_level <= LO) m_req = 1;
        end else if (wflow_ack) begin
            m_req    = 0;
            m_paused = !m_paused;
        end
    endtask

    task automatic check_all();
        check("wq2_rptr", wq2_rptr, hist[0]);
        check("wlevel", wlevel, m_level);
        check("walmost_full", walmost_full, m_almost);
        check("wxoff_req", wxoff_req, m_req && !m_paused);
        check("wxon_req", wxon_req, m_req && m_paused);
        check("wpaused", wpaused, m_paused);
        check("woverflow", woverflow, m_ov);
        check("wgray_err", wgray_err, m_err);
    endtask

    task automatic cycle();
        @(posedge wclk);
        if (!wrst_n) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) cycle();
        wrst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int wb, rb, phase;

        // Reset with a non-zero remote pointer, then watch it arrive two cycles later.
        rptr = 5'b10110;
        do_reset();
        check("t1_wq2_before", wq2_rptr, 0);
        run(2);
        check("t1_wq2_sync", wq2_rptr, 5'b10110);
        run(2);

        // Fill to the high mark and request XOFF.
        rptr = '0;
        wptr = '0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            wptr = b2g(i);
            cycle();
        end
        check("t2_level", wlevel, 12);
        check("t2_almost", walmost_full, 1);
        cycle();
        check("t2_xoff", wxoff_req, 1);
        run(2);
        wflow_ack = 1'b1;
        cycle();
        wflow_ack = 1'b0;
        check("t2_paused", wpaused, 1);
        check("t2_xoff_drop", wxoff_req, 0);

        // Drain to the low mark and request XON.
        for (int i = 1; i <= 8; i++) begin
            rptr = b2g(i);
            cycle();
        end
        run(3);
        check("t3_level", wlevel, 4);
        check("t3_xon", wxon_req, 1);
        run(2);
        wflow_ack = 1'b1;
        cycle();
        wflow_ack = 1'b0;
        check("t3_run", wpaused, 0);
        check("t3_xon_drop", wxon_req, 0);

        // Pointer wrap through the MSB.
        wptr = b2g(18);
        rptr = b2g(3);
        run(3);
        check("t4_level15", wlevel, 15);
        wptr = b2g(19);
        cycle();
        check("t4_level16", wlevel, 16);
        run(2);

        // Sticky error flags.
        wptr = '0;
        rptr = '0;
        run(3);
        werr_clr = 1'b1;
        cycle();
        werr_clr = 1'b0;
        check("t5_err_clr0", wgray_err, 0);
        rptr = 5'b00011;
        run(2);
        check("t5_gray_err", wgray_err, 1);
        winc  = 1'b1;
        wfull = 1'b1;
        cycle();
        winc  = 1'b0;
        wfull = 1'b0;
        check("t5_overflow", woverflow, 1);
        rptr = '0;
        run(3);
        werr_clr = 1'b1;
        cycle();
        check("t5_clr_ov", woverflow, 0);
        check("t5_clr_err", wgray_err, 0);
        winc  = 1'b1;
        wfull = 1'b1;
        cycle();
        werr_clr = 1'b0;
        winc     = 1'b0;
        wfull    = 1'b0;
        check("t5_set_wins", woverflow, 1);
        run(2);

        // Asynchronous reset while XOFF is pending.
        do_reset();
        wptr = b2g(12);
        rptr = '0;
        run(4);
        check("t6_xoff", wxoff_req, 1);
        wrst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_drop", wxoff_req, 0);
        check_all();
        run(2);
        wrst_n = 1'b1;
        cycle();
        check("t6_run_after", wxoff_req, 0);
        run(3);

        // Random legal pointer traffic with alternating fill/drain bias.
        wptr = '0;
        rptr = '0;
        do_reset();
        wb = 0;
        rb = 0;
        for (int c = 0; c < 3000; c++) begin
            phase = (c / 150) % 2;
            if ($urandom_range(0, 3) < (phase == 0 ? 3 : 1) && ((wb - rb) & 31) < 13) wb = (wb + 1) & 31;
            if ($urandom_range(0, 3) < (phase == 0 ? 1 : 3) && rb != wb) rb = (rb + 1) & 31;
            wptr      = b2g(wb);
            rptr      = b2g(rb);
            wflow_ack = ($urandom_range(0, 3) == 0);
            winc      = ($urandom_range(0, 7) == 0);
            wfull     = ($urandom_range(0, 7) == 0);
            werr_clr  = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
